// File: rtl/pcp_imem_pkg.sv
// Shared types and elaboration-time helpers for the PCP banked instruction memory.
package pcp_imem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StDone
  } load_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/pcp_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port whose output resets to zero.
module pcp_sdp_ram
  import pcp_imem_pkg::*;
#(
  parameter int unsigned Width = 75,
  parameter int unsigned Depth = 2048,
  localparam int unsigned AddrW = clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pcp_imem_banked.sv
// Multi-bank PCP instruction memory: core fetches from the active bank while the host
// loader packs narrow beats into the next bank; a swap handshake promotes that bank.
module pcp_imem_banked
  import pcp_imem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned INSTR_W   = 75,
  parameter int unsigned HOST_W    = 32,
  parameter int unsigned NUM_BANKS = 2,
  localparam int unsigned BEATS    = ceil_div(INSTR_W, HOST_W),
  localparam int unsigned BANK_W   = clog2(NUM_BANKS)
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic [ADDR_W-1:0]  fetch_addr,
  input  logic               fetch_en,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic               fetch_valid,
  input  logic               load_start,
  input  logic [ADDR_W-1:0]  load_base,
  input  logic [ADDR_W:0]    load_len,
  input  logic [HOST_W-1:0]  host_wdata,
  input  logic               host_wvalid,
  output logic               host_wready,
  output logic               load_busy,
  output logic               load_done,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic [BANK_W-1:0]  active_bank
);

  localparam int unsigned BEAT_W = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam int unsigned BUF_W  = BEATS * HOST_W;
  localparam int unsigned RAM_AW = BANK_W + ADDR_W;

  load_state_e       state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BUF_W-1:0]  buf_q;
  logic              pending_q;

  logic [BANK_W-1:0] load_bank;
  logic [ADDR_W-1:0] waddr;
  logic              beat_fire;
  logic              swap_go;
  logic              ram_we;

  assign load_bank = active_bank + 1'b1;
  assign waddr     = base_q + idx_q[ADDR_W-1:0];
  assign beat_fire = host_wvalid & host_wready;
  assign ram_we    = (state_q == StWrite);
  // A swap is only safe once no instruction is half-written into the load bank.
  assign swap_go   = (pending_q | swap_req) & ((state_q == StIdle) | (state_q == StDone));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      beat_q      <= '0;
      buf_q       <= '0;
      pending_q   <= 1'b0;
      host_wready <= 1'b0;
      load_busy   <= 1'b0;
      load_done   <= 1'b0;
      swap_ack    <= 1'b0;
      active_bank <= '0;
    end else begin
      load_done <= 1'b0;
      swap_ack  <= swap_go;
      pending_q <= swap_go ? 1'b0 : (pending_q | swap_req);
      // Bank flips at the end of the ack cycle, so a fetch issued alongside ack sees the old bank.
      if (swap_ack) active_bank <= active_bank + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (load_start) begin
            if (load_len != '0) begin
              state_q     <= StCollect;
              base_q      <= load_base;
              len_q       <= load_len;
              idx_q       <= '0;
              beat_q      <= '0;
              host_wready <= 1'b1;
              load_busy   <= 1'b1;
            end else begin
              state_q   <= StDone;
              load_done <= 1'b1;
            end
          end
        end
        StCollect: begin
          if (beat_fire) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
              if (beat_q == BEAT_W'(b)) buf_q[b*HOST_W +: HOST_W] <= host_wdata;
            end
            if (beat_q == BEAT_W'(BEATS - 1)) begin
              state_q     <= StWrite;
              host_wready <= 1'b0;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        StWrite: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q + 1'b1 == len_q) begin
            state_q   <= StDone;
            load_busy <= 1'b0;
            load_done <= 1'b1;
          end else begin
            state_q     <= StCollect;
            beat_q      <= '0;
            host_wready <= 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= fetch_en;
    end
  end

  if (BUF_W > INSTR_W) begin : gen_pad
    // Final-beat bits above INSTR_W are never written to the RAM.
    logic unused_pad;
    assign unused_pad = ^buf_q[BUF_W-1:INSTR_W];
  end

  pcp_sdp_ram #(
    .Width(INSTR_W),
    .Depth(NUM_BANKS << ADDR_W)
  ) u_ram (
    .clk_i  (clock),
    .rst_ni (nreset),
    .we_i   (ram_we),
    .waddr_i(RAM_AW'({load_bank, waddr})),
    .wdata_i(buf_q[INSTR_W-1:0]),
    .re_i   (fetch_en),
    .raddr_i(RAM_AW'({active_bank, fetch_addr})),
    .rdata_o(fetch_instr)
  );

endmodule

// File: tb/tb_pcp_imem_banked.sv
// Directed self-checking bench for pcp_imem_banked with the default parameters.
module tb_pcp_imem_banked;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic [9:0]  fetch_addr = '0;
  logic        fetch_en = 1'b0;
  logic [74:0] fetch_instr;
  logic        fetch_valid;
  logic        load_start = 1'b0;
  logic [9:0]  load_base = '0;
  logic [10:0] load_len = '0;
  logic [31:0] host_wdata = '0;
  logic        host_wvalid = 1'b0;
  logic        host_wready;
  logic        load_busy;
  logic        load_done;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic [0:0]  active_bank;

  int passed = 0;
  int total = 0;

  logic [74:0] word1;
  logic [74:0] word_a;
  logic [74:0] word_b;
  logic [74:0] word_c;
  logic [74:0] pre_010, pre_020, pre_030, pre_3ff, pre_000;

  always #5 clock = ~clock;

  pcp_imem_banked dut (
    .clock      (clock),
    .nreset     (nreset),
    .fetch_addr (fetch_addr),
    .fetch_en   (fetch_en),
    .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .host_wdata (host_wdata),
    .host_wvalid(host_wvalid),
    .host_wready(host_wready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .active_bank(active_bank)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_word(input logic [9:0] addr, output logic [74:0] val);
    fetch_en = 1'b1;
    fetch_addr = addr;
    step();
    val = fetch_instr;
    fetch_en = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
    host_wvalid = 1'b1;
    host_wdata = b0;
    step();
    host_wdata = b1;
    step();
    host_wdata = b2;
    step();
    host_wvalid = 1'b0;
  endtask

  task automatic start_load(input logic [9:0] base, input logic [10:0] len);
    load_start = 1'b1;
    load_base = base;
    load_len = len;
    step();
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    fetch_en = 1'b1;
    repeat (2) step();
    total++; if (fetch_instr !== '0) $display("FAIL rst_instr: got %h want 0", fetch_instr); else passed++;
    total++; if (fetch_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", fetch_valid); else passed++;
    total++; if (host_wready !== 1'b0) $display("FAIL rst_wready: got %b want 0", host_wready); else passed++;
    total++; if (load_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", load_busy); else passed++;
    total++; if (load_done !== 1'b0) $display("FAIL rst_done: got %b want 0", load_done); else passed++;
    total++; if (swap_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", swap_ack); else passed++;
    total++; if (active_bank !== 1'b0) $display("FAIL rst_bank: got %b want 0", active_bank); else passed++;
    fetch_en = 1'b0;
    nreset = 1'b1;
    step();
  endtask

  task automatic test_fetch_latency();
    fetch_en = 1'b1;
    fetch_addr = 10'h005;
    #1;
    total++; if (fetch_valid !== 1'b0) $display("FAIL fetch_early: got %b want 0", fetch_valid); else passed++;
    step();
    total++; if (fetch_valid !== 1'b1) $display("FAIL fetch_valid: got %b want 1", fetch_valid); else passed++;
    fetch_en = 1'b0;
    step();
    total++; if (fetch_valid !== 1'b0) $display("FAIL fetch_idle: got %b want 0", fetch_valid); else passed++;
  endtask

  task automatic test_load_single();
    start_load(10'h010, 11'd1);
    total++; if (load_busy !== 1'b1) $display("FAIL ls_busy: got %b want 1", load_busy); else passed++;
    total++; if (host_wready !== 1'b1) $display("FAIL ls_wready: got %b want 1", host_wready); else passed++;
    send_word(32'h11111111, 32'h22222222, 32'h000007FF);
    total++; if (host_wready !== 1'b0) $display("FAIL ls_wready_write: got %b want 0", host_wready); else passed++;
    total++; if (load_done !== 1'b0) $display("FAIL ls_done_early: got %b want 0", load_done); else passed++;
    step();
    total++; if (load_done !== 1'b1) $display("FAIL ls_done: got %b want 1", load_done); else passed++;
    total++; if (load_busy !== 1'b0) $display("FAIL ls_busy_done: got %b want 0", load_busy); else passed++;
    step();
    total++; if (load_done !== 1'b0) $display("FAIL ls_done_pulse: got %b want 0", load_done); else passed++;
  endtask

  task automatic test_load_wrap();
    logic [74:0] v;
    start_load(10'h3FF, 11'd2);
    send_word(32'hAAAA0001, 32'hAAAA0002, 32'hFFFFF805);
    total++; if (host_wready !== 1'b0) $display("FAIL lw_wready_write: got %b want 0", host_wready); else passed++;
    step();
    total++; if (host_wready !== 1'b1) $display("FAIL lw_wready_next: got %b want 1", host_wready); else passed++;
    total++; if (load_busy !== 1'b1) $display("FAIL lw_busy: got %b want 1", load_busy); else passed++;
    send_word(32'hBBBB0001, 32'hBBBB0002, 32'h00012345);
    step();
    total++; if (load_done !== 1'b1) $display("FAIL lw_done: got %b want 1", load_done); else passed++;
    step();
    fetch_word(10'h3FF, v);
    total++; if (v !== pre_3ff) $display("FAIL lw_bank0_3ff: got %h want %h", v, pre_3ff); else passed++;
    fetch_word(10'h000, v);
    total++; if (v !== pre_000) $display("FAIL lw_bank0_000: got %h want %h", v, pre_000); else passed++;
  endtask

  task automatic test_swap();
    logic [74:0] v;
    start_load(10'h020, 11'd1);
    host_wvalid = 1'b1;
    host_wdata = 32'hC0C0C0C0;
    step();
    host_wdata = 32'h0C0C0C0C;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    host_wdata = 32'h00000555;
    step();
    host_wvalid = 1'b0;
    total++; if (swap_ack !== 1'b0) $display("FAIL sw_ack_write: got %b want 0", swap_ack); else passed++;
    step();
    total++; if (load_done !== 1'b1) $display("FAIL sw_done: got %b want 1", load_done); else passed++;
    total++; if (swap_ack !== 1'b0) $display("FAIL sw_ack_done: got %b want 0", swap_ack); else passed++;
    step();
    total++; if (swap_ack !== 1'b1) $display("FAIL sw_ack: got %b want 1", swap_ack); else passed++;
    total++; if (active_bank !== 1'b0) $display("FAIL sw_bank_old: got %b want 0", active_bank); else passed++;
    fetch_word(10'h010, v);
    total++; if (v !== pre_010) $display("FAIL sw_fetch_old: got %h want %h", v, pre_010); else passed++;
    total++; if (swap_ack !== 1'b0) $display("FAIL sw_ack_pulse: got %b want 0", swap_ack); else passed++;
    total++; if (active_bank !== 1'b1) $display("FAIL sw_bank_new: got %b want 1", active_bank); else passed++;
    fetch_word(10'h010, v);
    total++; if (v !== word1) $display("FAIL sw_fetch_010: got %h want %h", v, word1); else passed++;
    fetch_word(10'h3FF, v);
    total++; if (v !== word_a) $display("FAIL sw_fetch_3ff: got %h want %h", v, word_a); else passed++;
    fetch_word(10'h000, v);
    total++; if (v !== word_b) $display("FAIL sw_fetch_000: got %h want %h", v, word_b); else passed++;
    fetch_word(10'h020, v);
    total++; if (v !== word_c) $display("FAIL sw_fetch_020: got %h want %h", v, word_c); else passed++;
    step();
    total++; if (active_bank !== 1'b1) $display("FAIL sw_single: got %b want 1", active_bank); else passed++;
  endtask

  task automatic test_reset_midload();
    logic [74:0] v;
    start_load(10'h030, 11'd1);
    host_wvalid = 1'b1;
    host_wdata = 32'hDEADBEEF;
    step();
    host_wdata = 32'hCAFEF00D;
    step();
    host_wvalid = 1'b0;
    nreset = 1'b0;
    #2;
    total++; if (load_busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", load_busy); else passed++;
    total++; if (host_wready !== 1'b0) $display("FAIL rm_wready: got %b want 0", host_wready); else passed++;
    total++; if (active_bank !== 1'b0) $display("FAIL rm_bank: got %b want 0", active_bank); else passed++;
    nreset = 1'b1;
    step();
    total++; if (host_wready !== 1'b0) $display("FAIL rm_idle: got %b want 0", host_wready); else passed++;
    fetch_word(10'h030, v);
    total++; if (v !== pre_030) $display("FAIL rm_nowrite: got %h want %h", v, pre_030); else passed++;
    start_load(10'h040, 11'd0);
    total++; if (load_done !== 1'b1) $display("FAIL rm_len0_done: got %b want 1", load_done); else passed++;
    total++; if (load_busy !== 1'b0) $display("FAIL rm_len0_busy: got %b want 0", load_busy); else passed++;
    step();
    total++; if (load_done !== 1'b0) $display("FAIL rm_len0_pulse: got %b want 0", load_done); else passed++;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    total++; if (swap_ack !== 1'b1) $display("FAIL rm_idle_ack: got %b want 1", swap_ack); else passed++;
    step();
    total++; if (active_bank !== 1'b1) $display("FAIL rm_idle_bank: got %b want 1", active_bank); else passed++;
    fetch_word(10'h010, v);
    total++; if (v !== word1) $display("FAIL rm_persist: got %h want %h", v, word1); else passed++;
  endtask

  initial begin
    word1  = {11'h7FF, 32'h22222222, 32'h11111111};
    word_a = {11'h005, 32'hAAAA0002, 32'hAAAA0001};
    word_b = {11'h345, 32'hBBBB0002, 32'hBBBB0001};
    word_c = {11'h555, 32'h0C0C0C0C, 32'hC0C0C0C0};
    test_reset();
    test_fetch_latency();
    fetch_word(10'h010, pre_010);
    fetch_word(10'h020, pre_020);
    fetch_word(10'h030, pre_030);
    fetch_word(10'h3FF, pre_3ff);
    fetch_word(10'h000, pre_000);
    test_load_single();
    test_load_wrap();
    test_swap();
    test_reset_midload();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
